imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted between request acceptance and response (legal 0..15).
REQ-002 SHALL have parameter MEM_BYTES, default 1024, meaning byte capacity of the instruction store (power of two).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  fetcher presents a fetch address.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_addr  input  32  byte address of the instruction word.
REQ-008 SHALL have port rsp_valid  output  1  rsp_data/rsp_misalign are valid.
REQ-009 SHALL have port rsp_ready  input  1  fetcher accepts the response this cycle.
REQ-010 SHALL have port rsp_data  output  32  fetched instruction word, big-endian.
REQ-011 SHALL have port rsp_misalign  output  1  latched req_addr[1:0] was nonzero.
REQ-012 SHALL have port ld_en  input  1  program-load byte write strobe.
REQ-013 SHALL have port ld_addr  input  log2(MEM_BYTES)  program-load byte address.
REQ-014 SHALL have port ld_data  input  8  program-load byte.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; request accepted on req_valid&&req_ready at a rising edge.
REQ-018 SHALL latch req_addr[log2(MEM_BYTES)-1:0] and req_addr[1:0]!=0 on acceptance; upper address bits ignored.
REQ-019 SHALL on acceptance go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else directly to RESP.
REQ-020 SHALL in WAIT decrement counter each cycle and go to RESP on the edge where counter is 0.
REQ-021 SHALL register rsp_data on the edge entering RESP as {mem[a], mem[a+1], mem[a+2], mem[a+3]}, a the latched address, each index modulo MEM_BYTES (wrap at top of store).
REQ-022 SHALL give rsp_valid first high exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_misalign stable in RESP until rsp_valid&&rsp_ready, then return to IDLE; no new request accepted in that same cycle.
REQ-024 SHALL still return data for misaligned addresses (unaligned 4-byte big-endian read) with rsp_misalign=1.
REQ-025 SHALL write ld_data to mem[ld_addr] on any edge with ld_en=1, in any state.
REQ-026 SHALL use read-before-write: a load to a byte on the edge entering RESP does not affect that response.
REQ-027 SHALL drive rsp_valid=0, rsp_misalign=0 outside RESP; rsp_data holds last value.

Reset
REQ-028 SHALL on rst force state IDLE, counter 0, rsp_valid 0, rsp_data 0, rsp_misalign 0, busy 0, abandoning any in-flight request without a response.
REQ-029 SHALL NOT clear memory contents on reset; rst has priority over ld_en and the handshake in the same cycle, but memory writes with ld_en during rst still occur.

Structure
REQ-030 SHALL place the FSM state enum, default WAIT_CYCLES and MEM_BYTES constants in the shared CPU package.
REQ-031 SHALL isolate storage in one sub-module imem_byte_ram (one byte write port, four combinational byte read ports with modulo indexing).

Verification
REQ-032 SHALL cover: load 0x00..0x03 = 12,34,56,78; WAIT_CYCLES=2; request 0x0 at edge 0 -> rsp_valid at edge 3, rsp_data=0x12345678, rsp_misalign=0.
REQ-033 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_data stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next edge.
REQ-034 SHALL cover: bytes 0x3FE..0x001 = AA,BB,CC,DD; request 0x3FE -> rsp_data=0xAABBCCDD, rsp_misalign=1.
REQ-035 SHALL cover: WAIT_CYCLES=0, request 0x4 -> rsp_valid on next edge; request address 0xFFFF_F404 aliases to 0x004.
REQ-036 SHALL cover: rst asserted in WAIT -> next edge IDLE, rsp_valid=0, rsp_data=0; following request returns unchanged memory data.
REQ-037 SHALL cover: ld_en to byte 0x8 on edge entering RESP for request 0x8 -> response shows old byte, next request shows new byte.

Source files
------------

// File: rtl/imem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder_pkg
//  Brief    : Shared constants and FSM state type for the instruction-memory
//             responder and its byte store.
//  Revision : 1.0 - initial release
// ============================================================================
package imem_responder_pkg;

  // Default number of wait states between request acceptance and response
  localparam int DEFAULT_WAIT_CYCLES = 2;
  // Default instruction store capacity in bytes (power of two)
  localparam int DEFAULT_MEM_BYTES   = 1024;
  // Wait-state counter width; covers WAIT_CYCLES up to 15
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

endpackage : imem_responder_pkg
`default_nettype wire

// File: rtl/imem_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module   : imem_byte_ram
//  Brief    : Byte-wide instruction store. One synchronous byte write port and
//             four combinational byte read ports at rd_addr+0..3, wrapping at
//             the top of the store.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_byte_ram
  import imem_responder_pkg::*;
#(
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(MEM_BYTES)-1:0] wr_addr,
  input  logic [7:0]                   wr_data,
  input  logic [$clog2(MEM_BYTES)-1:0] rd_addr,
  output logic [3:0][7:0]              rd_bytes
);

  localparam int AW = $clog2(MEM_BYTES);

  logic [7:0] mem_q [MEM_BYTES];

  // Byte write port; contents are never reset so a loaded program survives rst
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port i returns byte rd_addr+i; the AW-bit sum wraps modulo MEM_BYTES
  for (genvar i = 0; i < 4; i++) begin : g_rd_port
    assign rd_bytes[i] = mem_q[rd_addr + AW'(i)];
  end

endmodule : imem_byte_ram
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : imem_responder
//  Brief    : Instruction fetch responder. Accepts one byte-addressed fetch,
//             inserts WAIT_CYCLES wait states, then presents a big-endian
//             32-bit word (unaligned reads allowed, flagged) until consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int MEM_BYTES   = DEFAULT_MEM_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [31:0]                  rsp_data,
  output logic                         rsp_misalign,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_BYTES)-1:0] ld_addr,
  input  logic [7:0]                   ld_data,
  output logic                         busy
);

  localparam int             AW        = $clog2(MEM_BYTES);
  localparam logic [CNT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  imem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              mis_q, mis_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_misalign_q, rsp_misalign_d;

  logic [AW-1:0]     rd_addr;
  logic [3:0][7:0]   rd_bytes;
  logic [31:0]       rd_word;

  // With zero wait states the word is captured on the acceptance edge, before
  // the address is latched, so the store is read from req_addr while idle.
  assign rd_addr = (state_q == ST_IDLE) ? req_addr[AW-1:0] : addr_q;
  assign rd_word = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};

  imem_byte_ram #(
    .MEM_BYTES (MEM_BYTES)
  ) u_ram (
    .clk      (clk),
    .wr_en    (ld_en),
    .wr_addr  (ld_addr),
    .wr_data  (ld_data),
    .rd_addr  (rd_addr),
    .rd_bytes (rd_bytes)
  );

  // Next-state and next-output logic for the fetch handshake
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    mis_d          = mis_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_misalign_d = rsp_misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr[AW-1:0];
          mis_d  = |req_addr[1:0];
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d        = ST_RESP;
            rsp_valid_d    = 1'b1;
            rsp_data_d     = rd_word;
            rsp_misalign_d = |req_addr[1:0];
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d        = ST_RESP;
          rsp_valid_d    = 1'b1;
          rsp_data_d     = rd_word;
          rsp_misalign_d = mis_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d        = ST_IDLE;
          rsp_valid_d    = 1'b0;
          rsp_misalign_d = 1'b0;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        rsp_valid_d    = 1'b0;
        rsp_misalign_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      mis_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      mis_q          <= mis_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_misalign_q <= rsp_misalign_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_misalign = rsp_misalign_q;

endmodule : imem_responder
`default_nettype wire
